// File: rtl/ahbl_sram_v2.sv
// ahbl_sram_v2: AHB-Lite slave wrapping an inferred single-port SRAM array.
//   32/64-bit data, any depth, 0..3 read wait states, write-to-read forwarding,
//   two-cycle ERROR response for out-of-range, misaligned and oversize transfers.
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL, HREADYIN        select and bus ready from the interconnect
//   HTRANS, HBURST        transfer type; burst type (ignored)
//   HSIZE, HADDR, HWRITE  address-phase control
//   HWDATA                write data (data phase)
//   HREADYOUT, HRDATA     slave ready, read data
//   HRESP                 00 OKAY, 01 ERROR
module ahbl_sram_v2 #(
   parameter int unsigned AHB_DWIDTH = 32,
   parameter int unsigned AHB_AWIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned RD_WAIT    = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic                  HREADYIN,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HBURST,
   input  logic [2:0]            HSIZE,
   input  logic [AHB_AWIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [AHB_DWIDTH-1:0] HWDATA,
   output logic                  HREADYOUT,
   output logic [AHB_DWIDTH-1:0] HRDATA,
   output logic [1:0]            HRESP
);
   localparam int unsigned NB = AHB_DWIDTH / 8;
   localparam int unsigned L  = $clog2(NB);
   localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned XW = AHB_AWIDTH - L;

   typedef enum logic [2:0] {StIdle, StWr, StRdWait, StRd, StErr1, StErr2} state_e;

   state_e                state_q, state_d;
   logic [1:0]            wait_q;
   logic [IW-1:0]         wr_idx_q, rd_idx_q;
   logic [NB-1:0]         wr_strb_q;
   logic [AHB_DWIDTH-1:0] hrdata_q;
   logic                  hreadyout_q;
   logic [1:0]            hresp_q;

   logic [AHB_DWIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept, acc_err;
   logic [XW-1:0]         acc_word;
   logic [IW-1:0]         acc_idx, rd_src_idx;
   logic [L-1:0]          acc_lane;
   logic [NB-1:0]         acc_strb;
   logic [AHB_DWIDTH-1:0] rd_word;
   logic                  unused_in;

   assign unused_in = ^{HBURST, HTRANS[0]};

   // Address-phase decode.
   always_comb begin
      accept   = 1'b0;
      acc_err  = 1'b0;
      acc_word = HADDR[AHB_AWIDTH-1:L];
      acc_lane = HADDR[L-1:0];
      acc_idx  = acc_word[IW-1:0];
      acc_strb = '0;
      // No address is sampled while the slave is stalling the bus.
      if (state_q inside {StIdle, StWr, StRd, StErr2}) begin
         accept = HSEL & HREADYIN & HTRANS[1];
      end
      if (64'(acc_word) >= 64'(MEM_DEPTH)) acc_err = 1'b1;
      if (32'(HSIZE) > L) acc_err = 1'b1;
      if ((32'(acc_lane) & ((32'd1 << HSIZE) - 32'd1)) != 32'd0) acc_err = 1'b1;
      for (int b = 0; b < int'(NB); b++) begin
         acc_strb[b] = (b >= int'(acc_lane)) && (b < int'(acc_lane) + (1 << HSIZE));
      end
   end

   // Read word: taken from the accepted address, or the latched one after wait states.
   // Bytes being written in the current data phase are forwarded from HWDATA.
   always_comb begin
      rd_src_idx = (state_q == StRdWait) ? rd_idx_q : acc_idx;
      rd_word    = mem[rd_src_idx];
      for (int b = 0; b < int'(NB); b++) begin
         if (state_q == StWr && wr_idx_q == rd_src_idx && wr_strb_q[b]) begin
            rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d = StIdle;
      unique case (state_q)
         StRdWait: state_d = (wait_q == 2'd0) ? StRd : StRdWait;
         StErr1:   state_d = StErr2;
         default: begin
            if (accept) begin
               if (acc_err)          state_d = StErr1;
               else if (HWRITE)      state_d = StWr;
               else if (RD_WAIT > 0) state_d = StRdWait;
               else                  state_d = StRd;
            end
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= StIdle;
         wait_q      <= 2'd0;
         wr_idx_q    <= '0;
         wr_strb_q   <= '0;
         rd_idx_q    <= '0;
         hrdata_q    <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         hreadyout_q <= !(state_d inside {StRdWait, StErr1});
         hresp_q     <= (state_d inside {StErr1, StErr2}) ? 2'b01 : 2'b00;
         if (accept && !acc_err) begin
            wr_idx_q  <= acc_idx;
            wr_strb_q <= acc_strb;
            rd_idx_q  <= acc_idx;
         end
         if (state_d == StRdWait && state_q != StRdWait) begin
            wait_q <= 2'(RD_WAIT - 1);
         end else if (state_q == StRdWait && wait_q != 2'd0) begin
            wait_q <= wait_q - 2'd1;
         end
         if (state_d == StRd) hrdata_q <= rd_word;
      end
   end

   // Pending write commits at the edge ending its data phase; reset drops it.
   always_ff @(posedge HCLK) begin
      if (!HRESET && state_q == StWr) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (wr_strb_q[b]) mem[wr_idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
         end
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahbl_sram_v2.sv
module tb_ahbl_sram_v2;
   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic [1:0]  htrans = 2'b00;
   logic [2:0]  hburst = 3'b000;
   logic [2:0]  hsize = 3'd2;
   logic [31:0] haddr = '0;
   logic        hwrite = 1'b0;
   logic [63:0] hwdata = '0;
   logic        hsel_a = 1'b0, hsel_b = 1'b0, hsel_c = 1'b0;

   logic        rdy_a, rdy_b, rdy_c;
   logic [1:0]  resp_a, resp_b, resp_c;
   logic [31:0] rd_a, rd_c;
   logic [63:0] rd_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 hclk = ~hclk;

   // a: 32-bit, 1000 words, no wait; b: 64-bit; c: 32-bit with 2 read wait states.
   // Each slave's HREADYIN is its own HREADYOUT, as with a single-slave mux.
   ahbl_sram_v2 #(.AHB_DWIDTH(32), .AHB_AWIDTH(32), .MEM_DEPTH(1000), .RD_WAIT(0)) u_a (
      .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_a), .HREADYIN(rdy_a), .HTRANS(htrans),
      .HBURST(hburst), .HSIZE(hsize), .HADDR(haddr), .HWRITE(hwrite), .HWDATA(hwdata[31:0]),
      .HREADYOUT(rdy_a), .HRDATA(rd_a), .HRESP(resp_a));
   ahbl_sram_v2 #(.AHB_DWIDTH(64), .AHB_AWIDTH(32), .MEM_DEPTH(64), .RD_WAIT(0)) u_b (
      .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_b), .HREADYIN(rdy_b), .HTRANS(htrans),
      .HBURST(hburst), .HSIZE(hsize), .HADDR(haddr), .HWRITE(hwrite), .HWDATA(hwdata),
      .HREADYOUT(rdy_b), .HRDATA(rd_b), .HRESP(resp_b));
   ahbl_sram_v2 #(.AHB_DWIDTH(32), .AHB_AWIDTH(32), .MEM_DEPTH(1024), .RD_WAIT(2)) u_c (
      .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_c), .HREADYIN(rdy_c), .HTRANS(htrans),
      .HBURST(hburst), .HSIZE(hsize), .HADDR(haddr), .HWRITE(hwrite), .HWDATA(hwdata[31:0]),
      .HREADYOUT(rdy_c), .HRDATA(rd_c), .HRESP(resp_c));

   task automatic addr_ph(input logic wr, input logic [2:0] sz, input logic [31:0] a);
      htrans = 2'b10;
      hwrite = wr;
      hsize  = sz;
      haddr  = a;
   endtask

   task automatic bus_idle();
      htrans = 2'b00;
      hwrite = 1'b0;
   endtask

   task automatic step();
      @(negedge hclk);
   endtask

   task automatic test_reset();
      hreset = 1'b1;
      bus_idle();
      repeat (3) step();
      n_cmp++; if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL rst_rdy: got %b want 1", rdy_a); end
      n_cmp++; if (resp_a !== 2'b00) begin n_bad++; $display("FAIL rst_resp: got %b want 00", resp_a); end
      n_cmp++; if (rd_a !== 32'h0) begin n_bad++; $display("FAIL rst_rdata_a: got %h want 0", rd_a); end
      n_cmp++; if (rd_b !== 64'h0) begin n_bad++; $display("FAIL rst_rdata_b: got %h want 0", rd_b); end
      n_cmp++; if (rdy_c !== 1'b1) begin n_bad++; $display("FAIL rst_rdy_c: got %b want 1", rdy_c); end
      hreset = 1'b0;
      step();
   endtask

   task automatic test_word_rw();
      hsel_a = 1'b1;
      addr_ph(1'b1, 3'd2, 32'h10);
      step();
      n_cmp++; if (rdy_a !== 1'b1 || resp_a !== 2'b00) begin
         n_bad++; $display("FAIL wr_dphase: got rdy=%b resp=%b want 1/00", rdy_a, resp_a); end
      hwdata = 64'hDEADBEEF;
      addr_ph(1'b0, 3'd2, 32'h10);
      step();
      n_cmp++; if (rd_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fwd_word: got %h want deadbeef", rd_a); end
      bus_idle();
      step();
      n_cmp++; if (rd_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_hold: got %h want deadbeef", rd_a); end
      addr_ph(1'b0, 3'd2, 32'h10);
      step();
      n_cmp++; if (rd_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL iso_read: got %h want deadbeef", rd_a); end
      // Word write, then halfword into the upper lanes, then read: partial forward.
      addr_ph(1'b1, 3'd2, 32'h14);
      step();
      hwdata = 64'h12345678;
      addr_ph(1'b1, 3'd1, 32'h16);
      step();
      hwdata = 64'hAAAA0000;
      addr_ph(1'b0, 3'd2, 32'h14);
      step();
      n_cmp++; if (rd_a !== 32'hAAAA5678) begin n_bad++; $display("FAIL fwd_half: got %h want aaaa5678", rd_a); end
      bus_idle();
      step();
      hsel_a = 1'b0;
   endtask

   task automatic test_byte64();
      hsel_b = 1'b1;
      addr_ph(1'b1, 3'd3, 32'h8);
      step();
      hwdata = 64'h0;
      addr_ph(1'b1, 3'd0, 32'hD);
      step();
      hwdata = 64'h0000AB0000000000;
      addr_ph(1'b0, 3'd3, 32'h8);
      step();
      n_cmp++; if (rd_b !== 64'h0000AB0000000000) begin
         n_bad++; $display("FAIL byte64_fwd: got %h want 0000ab0000000000", rd_b); end
      hwdata = 64'hFFFFFFFFFFFFFFFF;
      bus_idle();
      step();
      addr_ph(1'b0, 3'd3, 32'h8);
      step();
      n_cmp++; if (rd_b !== 64'h0000AB0000000000) begin
         n_bad++; $display("FAIL byte64_read: got %h want 0000ab0000000000", rd_b); end
      bus_idle();
      step();
      hsel_b = 1'b0;
   endtask

   task automatic test_wait();
      hsel_c = 1'b1;
      addr_ph(1'b1, 3'd2, 32'h0);
      step();
      hwdata = 64'h11111111;
      addr_ph(1'b1, 3'd2, 32'h4);
      step();
      hwdata = 64'h22222222;
      bus_idle();
      step();
      addr_ph(1'b0, 3'd2, 32'h0);
      step();
      n_cmp++; if (rdy_c !== 1'b0) begin n_bad++; $display("FAIL wait_c1: got %b want 0", rdy_c); end
      addr_ph(1'b0, 3'd2, 32'h4);  // offered during the stall, held until ready
      step();
      n_cmp++; if (rdy_c !== 1'b0) begin n_bad++; $display("FAIL wait_c2: got %b want 0", rdy_c); end
      step();
      n_cmp++; if (rdy_c !== 1'b1 || rd_c !== 32'h11111111) begin
         n_bad++; $display("FAIL wait_c3: got rdy=%b data=%h want 1/11111111", rdy_c, rd_c); end
      step();
      bus_idle();
      n_cmp++; if (rdy_c !== 1'b0 || rd_c !== 32'h11111111) begin
         n_bad++; $display("FAIL wait2_c1: got rdy=%b data=%h want 0/11111111", rdy_c, rd_c); end
      step();
      n_cmp++; if (rdy_c !== 1'b0) begin n_bad++; $display("FAIL wait2_c2: got %b want 0", rdy_c); end
      step();
      n_cmp++; if (rdy_c !== 1'b1 || rd_c !== 32'h22222222) begin
         n_bad++; $display("FAIL wait2_c3: got rdy=%b data=%h want 1/22222222", rdy_c, rd_c); end
      step();
      hsel_c = 1'b0;
   endtask

   task automatic test_errors();
      hsel_a = 1'b1;
      // Write word 0, with an out-of-range read issued in its data phase.
      addr_ph(1'b1, 3'd2, 32'h0);
      step();
      hwdata = 64'h01020304;
      addr_ph(1'b0, 3'd2, 32'hFA0);
      step();
      n_cmp++; if (rdy_a !== 1'b0 || resp_a !== 2'b01) begin
         n_bad++; $display("FAIL oor_err1: got rdy=%b resp=%b want 0/01", rdy_a, resp_a); end
      bus_idle();
      step();
      n_cmp++; if (rdy_a !== 1'b1 || resp_a !== 2'b01) begin
         n_bad++; $display("FAIL oor_err2: got rdy=%b resp=%b want 1/01", rdy_a, resp_a); end
      step();
      n_cmp++; if (rdy_a !== 1'b1 || resp_a !== 2'b00) begin
         n_bad++; $display("FAIL oor_after: got rdy=%b resp=%b want 1/00", rdy_a, resp_a); end
      addr_ph(1'b1, 3'd1, 32'h3);
      step();
      n_cmp++; if (rdy_a !== 1'b0 || resp_a !== 2'b01) begin
         n_bad++; $display("FAIL mis_err1: got rdy=%b resp=%b want 0/01", rdy_a, resp_a); end
      hwdata = 64'hFFFFFFFF;
      bus_idle();
      step();
      n_cmp++; if (rdy_a !== 1'b1 || resp_a !== 2'b01) begin
         n_bad++; $display("FAIL mis_err2: got rdy=%b resp=%b want 1/01", rdy_a, resp_a); end
      step();
      addr_ph(1'b0, 3'd2, 32'h0);
      step();
      n_cmp++; if (rd_a !== 32'h01020304 || resp_a !== 2'b00) begin
         n_bad++; $display("FAIL err_mem: got %h resp=%b want 01020304/00", rd_a, resp_a); end
      // Last in-range word (999).
      addr_ph(1'b1, 3'd2, 32'hF9C);
      step();
      hwdata = 64'h5A5A5A5A;
      bus_idle();
      step();
      addr_ph(1'b0, 3'd2, 32'hF9C);
      step();
      n_cmp++; if (rd_a !== 32'h5A5A5A5A || resp_a !== 2'b00) begin
         n_bad++; $display("FAIL last_word: got %h resp=%b want 5a5a5a5a/00", rd_a, resp_a); end
      bus_idle();
      step();
      hsel_a = 1'b0;
   endtask

   task automatic test_reset_mid();
      hsel_a = 1'b1;
      addr_ph(1'b1, 3'd2, 32'h20);
      step();
      hwdata = 64'h55555555;
      bus_idle();
      step();
      addr_ph(1'b1, 3'd2, 32'h20);
      step();
      hwdata = 64'h99999999;
      hreset = 1'b1;
      bus_idle();
      step();
      n_cmp++; if (rdy_a !== 1'b1 || rd_a !== 32'h0) begin
         n_bad++; $display("FAIL rst_mid: got rdy=%b data=%h want 1/0", rdy_a, rd_a); end
      hreset = 1'b0;
      step();
      addr_ph(1'b0, 3'd2, 32'h20);
      step();
      n_cmp++; if (rd_a !== 32'h55555555) begin
         n_bad++; $display("FAIL rst_nocommit: got %h want 55555555", rd_a); end
      bus_idle();
      step();
      hsel_a = 1'b0;
      hsel_c = 1'b1;
      addr_ph(1'b0, 3'd2, 32'h0);
      step();
      n_cmp++; if (rdy_c !== 1'b0) begin n_bad++; $display("FAIL rdwait_pre: got %b want 0", rdy_c); end
      hreset = 1'b1;
      bus_idle();
      step();
      n_cmp++; if (rdy_c !== 1'b1 || resp_c !== 2'b00) begin
         n_bad++; $display("FAIL rdwait_rst: got rdy=%b resp=%b want 1/00", rdy_c, resp_c); end
      hreset = 1'b0;
      step();
      hsel_c = 1'b0;
   endtask

   initial begin
      step();
      test_reset();
      test_word_rw();
      test_byte64();
      test_wait();
      test_errors();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ahbl_sram_v2.md
# ahbl_sram_v2

Parametrised AHB-Lite slave with an embedded, inferred single-port SRAM array. It is the next-generation SRAM slave for the fabric AHB bus. Over the existing 32-bit controller it adds:
- selectable 32/64-bit data width and arbitrary depth;
- programmable read wait states;
- write-to-read data forwarding;
- AHB ERROR responses for out-of-range, misaligned and oversize transfers.

## Interface
- AHB_DWIDTH, 32, data bus width; legal values 32 or 64.
- AHB_AWIDTH, 32, address bus width.
- MEM_DEPTH, 1024, number of AHB_DWIDTH-bit words; need not be a power of 2.
- RD_WAIT, 0, extra wait states per read data phase; legal range 0..3.
- HCLK  in  1  single clock; all logic rises on HCLK.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select.
- HREADYIN  in  1  bus ready from the interconnect mux.
- HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HBURST  in  3  accepted but unused; each beat is handled as a single transfer.
- HSIZE  in  3  transfer size: 0=byte, 1=half, 2=word, 3=dword.
- HADDR  in  AHB_AWIDTH  byte address.
- HWRITE  in  1  1 = write.
- HWDATA  in  AHB_DWIDTH  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready.
- HRDATA  out  AHB_DWIDTH  read data.
- HRESP  out  2  00 = OKAY, 01 = ERROR.

## Operation
- **Address-phase accept:** a transfer is accepted on an HCLK edge when HSEL & HREADYIN & HTRANS[1] are all 1. IDLE/BUSY beats get a zero-wait OKAY.
- **Address decode:**
  - L = log2(AHB_DWIDTH/8).
  - Word index = HADDR[AHB_AWIDTH-1:L].
  - Byte lane = HADDR[L-1:0].
- **Error conditions:** any of the following gives ERROR, with no memory write:
  - word index >= MEM_DEPTH;
  - HSIZE > L;
  - HADDR not aligned to 2^HSIZE.
- **Byte strobes:** derived from HSIZE and the byte lane (little-endian). Only strobed bytes are written. Reads always return the full word on HRDATA.
- **Write path:** the accepted write is held in a pending-write register (word index and strobes). HWDATA is merged into the array at the edge that ends the data phase.
- **Forwarding:** if a read's address phase coincides with the data phase of a write to the same word, the returned data is the array word with the strobed bytes taken from that write. Stale data is never returned.
- **State machine:** IDLE, WR, RDWAIT, RD, ERR1, ERR2.
  - IDLE: accepted write -> WR; accepted in-range read -> RDWAIT if RD_WAIT>0, else RD; error -> ERR1.
  - WR / RD: another accept -> the corresponding next state; no accept -> IDLE.
  - RDWAIT: counts RD_WAIT cycles, then -> RD.
  - ERR1 -> ERR2 unconditionally.
  - ERR2: accept -> next state; no accept -> IDLE.
- **Outputs by state:**
  - WR, RD: HREADYOUT=1, HRESP=00.
  - RDWAIT: HREADYOUT=0, HRESP=00.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
- **HRDATA hold:** HRDATA keeps its last value outside RD.
- **Reset:** HRESET=1 at any edge, in any state, moves the block to IDLE. It drops the pending write (not committed), clears the wait counter and clears HRDATA. Array contents are not cleared.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=00, HRDATA=0.
- **Write:** address phase in cycle N; data phase in N+1 with HREADYOUT=1; the array is updated at the end of N+1. Zero wait states.
- **Read:** address phase in N; HREADYOUT=0 for cycles N+1..N+RD_WAIT; valid HRDATA with HREADYOUT=1 in cycle N+1+RD_WAIT.
- **Error:** address phase in N; ERR1 in N+1, ERR2 in N+2. Total 2 cycles.
- **Back-to-back:** transfers pipeline with no idle cycle. A new address phase is accepted in the last (HREADYOUT=1) cycle of the previous data phase.
- **No accept while stalled:** no address is sampled while HREADYOUT=0, because HREADYIN is low during the stall.
- **Error during a write data phase:** the pending write still commits.

## Test plan
- **Reset values:** hold HRESET 3 cycles -> HREADYOUT=1, HRESP=00, HRDATA=0.
- **Word write/read:** DWIDTH=32, RD_WAIT=0. Write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF in the read data phase, via forwarding. A later isolated read of 0x10 -> same value.
- **Byte write, 64-bit:** DWIDTH=64. Word write of all-zero to 0x8, then byte write 0xAB to 0xD -> a read of 0x8 returns 0x0000AB0000000000.
- **Read wait states:** RD_WAIT=2, read -> HREADYOUT low for exactly 2 cycles, data in the 3rd cycle. A NONSEQ read offered during the stall is ignored until HREADYOUT=1.
- **Errors:** MEM_DEPTH=1000, DWIDTH=32.
  - Read 0xFA0 (word 1000) -> ERR1 then ERR2, i.e. HREADYOUT 0 then 1 with HRESP=01 both cycles.
  - Halfword write to 0x3 -> same ERROR sequence, and the array is unchanged.
- **Reset mid-operation:** assert HRESET during the data phase of a write to 0x20 -> the array at 0x20 keeps its old value. During RDWAIT, HRESET -> next cycle HREADYOUT=1.
